core_fetch_unpack: RTL and testbench

- Front-end stage between instruction memory and decode.
- Generates 16-byte-aligned fetch addresses, buffers returned 128-bit instruction packets (4 x 32-bit instructions), and issues them to decode one at a time with their PC.
- Handles branch/exception redirects, including flushing in-flight and buffered packets.

---
 rtl/core_fetch_unpack.sv | 165 ++++++++++++++++
 tb/tb_core_fetch_unpack.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_unpack.sv
// core_fetch_unpack
//   Front-end stage between instruction memory and decode. Issues 16-byte
//   aligned packet fetches, buffers the returned packets (INSTR_PER_PKT
//   instructions each) and hands them to decode one instruction per
//   handshake together with its PC. A redirect flushes everything buffered
//   and marks any in-flight packet as stale.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   redirect_valid_i    redirect fetch to redirect_pc_i (highest priority)
//   redirect_pc_i       redirect target, 4-byte aligned
//   mem_req_valid_o     fetch request valid
//   mem_req_ready_i     memory accepts the request
//   mem_req_addr_o      packet address, low offset bits are zero
//   mem_rsp_valid_i     packet return, no backpressure
//   mem_rsp_packet_i    returned packet, slot k at bits [32k+31:32k]
//   instr_valid_o       instruction valid to decode
//   instr_ready_i       decode accepts
//   instr_o             instruction
//   instr_pc_o          PC of instr_o
module core_fetch_unpack #(
    parameter int PKT_DEPTH = 2,
    parameter int INSTR_PER_PKT = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 redirect_valid_i,
    input  logic [PC_WIDTH-1:0]                  redirect_pc_i,
    output logic                                 mem_req_valid_o,
    input  logic                                 mem_req_ready_i,
    output logic [PC_WIDTH-1:0]                  mem_req_addr_o,
    input  logic                                 mem_rsp_valid_i,
    input  logic [INSTR_WIDTH*INSTR_PER_PKT-1:0] mem_rsp_packet_i,
    output logic                                 instr_valid_o,
    input  logic                                 instr_ready_i,
    output logic [INSTR_WIDTH-1:0]               instr_o,
    output logic [PC_WIDTH-1:0]                  instr_pc_o
);

    localparam int SLOT_W  = $clog2(INSTR_PER_PKT);
    localparam int BYTE_SH = $clog2(INSTR_WIDTH / 8);
    localparam int OFS_W   = SLOT_W + BYTE_SH;
    localparam int PTR_W   = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
    localparam int CNT_W   = $clog2(PKT_DEPTH + 1);

    localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(PKT_DEPTH);
    localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(INSTR_PER_PKT - 1);
    localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(PKT_DEPTH - 1);
    localparam logic [PC_WIDTH-1:0] PKT_BYTES = PC_WIDTH'(1) << OFS_W;

    typedef logic [INSTR_PER_PKT-1:0][INSTR_WIDTH-1:0] pkt_t;

    function automatic logic [PC_WIDTH-1:0] align_pkt(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
    endfunction

    function automatic logic [SLOT_W-1:0] slot_of(input logic [PC_WIDTH-1:0] pc);
        return pc[OFS_W-1:BYTE_SH];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // fetch control
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [SLOT_W-1:0]   start_slot;
    logic                outstanding;
    logic                drop;
    logic [PC_WIDTH-1:0] req_base;
    logic [SLOT_W-1:0]   req_slot;

    // packet buffer
    pkt_t                pkt_p0  [PKT_DEPTH];
    logic [PC_WIDTH-1:0] base_p0 [PKT_DEPTH];
    logic [SLOT_W-1:0]   slot_p0 [PKT_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;

    logic                busy;
    logic                req_fire;
    logic                rsp_take;
    logic                push;
    logic                fire_out;
    logic                pop;
    pkt_t                head_pkt;
    logic [PC_WIDTH-1:0] head_base;
    logic [SLOT_W-1:0]   head_slot;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[BYTE_SH-1:0];

    // busy: memory still owes one response, either wanted or stale
    assign busy            = outstanding | drop;
    assign mem_req_valid_o = !rst && !busy && (count < DEPTH_C);
    assign mem_req_addr_o  = mem_req_valid_o ? fetch_pc : '0;
    assign req_fire        = mem_req_valid_o & mem_req_ready_i;
    assign rsp_take        = mem_rsp_valid_i & busy;
    assign push            = rsp_take & outstanding & ~redirect_valid_i;

    assign head_pkt      = pkt_p0[rd_ptr];
    assign head_base     = base_p0[rd_ptr];
    assign head_slot     = slot_p0[rd_ptr];
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? head_pkt[head_slot] : '0;
    assign instr_pc_o    = instr_valid_o ?
                           head_base + (PC_WIDTH'(head_slot) << BYTE_SH) : '0;
    assign fire_out      = instr_valid_o & instr_ready_i;
    assign pop           = fire_out & (head_slot == LAST_SLOT);

    // stage p0: fetch control and buffer occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= align_pkt(RESET_PC);
            start_slot  <= slot_of(RESET_PC);
            outstanding <= 1'b0;
            // a request still in flight at reset returns later and must be discarded
            drop        <= outstanding & ~mem_rsp_valid_i;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid_i) begin
            fetch_pc    <= align_pkt(redirect_pc_i);
            start_slot  <= slot_of(redirect_pc_i);
            outstanding <= 1'b0;
            // whatever memory still owes after this edge is stale
            drop        <= req_fire | (busy & ~mem_rsp_valid_i);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                outstanding <= 1'b1;
                fetch_pc    <= fetch_pc + PKT_BYTES;
                start_slot  <= '0;
            end
            if (rsp_take) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // stage p0: packet storage and per-entry slot pointer
    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_base <= fetch_pc;
            req_slot <= start_slot;
        end
        if (push) begin
            pkt_p0[wr_ptr]  <= mem_rsp_packet_i;
            base_p0[wr_ptr] <= req_base;
            slot_p0[wr_ptr] <= req_slot;
        end
        if (fire_out && !pop) slot_p0[rd_ptr] <= head_slot + 1'b1;
    end

endmodule

// File: tb/tb_core_fetch_unpack.sv
// Scoreboard bench for core_fetch_unpack: a memory model answers requests
// after rsp_lat cycles, the stimulus pushes expected {instr, pc} pairs,
// and negedge monitors compare issued instructions and request addresses.
module tb_core_fetch_unpack;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid_i;
    logic [31:0]  redirect_pc_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rsp_valid_i;
    logic [127:0] mem_rsp_packet_i;
    logic         instr_valid_o;
    logic         instr_ready_i;
    logic [31:0]  instr_o;
    logic [31:0]  instr_pc_o;

    always #5 clk = ~clk;

    core_fetch_unpack #(
        .PKT_DEPTH(2), .INSTR_PER_PKT(4), .INSTR_WIDTH(32),
        .PC_WIDTH(32), .RESET_PC(32'h0000_0100)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_packet_i(mem_rsp_packet_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          rsp_lat   = 1;
    int          req_count = 0;
    logic [31:0] exp_fetch = 32'h0000_0100;
    logic [31:0] redir_addr = '0;
    logic        redir_pend = 1'b0;
    logic [31:0] rsp_addr;
    exp_t        mon_e;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({instr_of(pc), pc});
    endtask

    task automatic expect_run(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) expect_pc(pc + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        instr_ready_i = 1'b1;
        while (exp_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        instr_ready_i = 1'b0;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic redirect(input logic [31:0] pc);
        // only an instruction being accepted in the redirect cycle survives
        if (instr_valid_o && instr_ready_i) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
        end else begin
            exp_q.delete();
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        redir_addr       = {pc[31:4], 4'h0};
        redir_pend       = 1'b1;
        tick();
        redirect_valid_i = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int rc = req_count;
        int n = 0;
        while (req_count == rc && n < 20) begin
            tick();
            n++;
        end
        check(name, req_count - rc, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, mem_req_valid_o, 0);
        check({tag, "_req_addr"}, mem_req_addr_o, 0);
        check({tag, "_instr_valid"}, instr_valid_o, 0);
        check({tag, "_instr"}, instr_o, 0);
        check({tag, "_instr_pc"}, instr_pc_o, 0);
    endtask

    // memory responder
    initial begin
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_packet_i = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_rsp_valid_i  = 1'b0;
            mem_rsp_packet_i = '0;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                rsp_addr = pend_addr.pop_front();
                void'(pend_due.pop_front());
                mem_rsp_valid_i = 1'b1;
                for (int k = 0; k < 4; k++)
                    mem_rsp_packet_i[32*k +: 32] = instr_of(rsp_addr + 32'(4 * k));
            end
        end
    end

    // monitors
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid_o && mem_req_ready_i) begin
                check("req_addr", mem_req_addr_o, exp_fetch);
                pend_addr.push_back(mem_req_addr_o);
                pend_due.push_back(cyc + rsp_lat);
                exp_fetch = exp_fetch + 32'h10;
                req_count++;
            end
            if (redir_pend) begin
                exp_fetch  = redir_addr;
                redir_pend = 1'b0;
            end
            if (!rst && instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, required no instruction",
                             instr_pc_o, instr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_pc", instr_pc_o, mon_e.pc);
                    check("instr", instr_o, mon_e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          changes;
        int          rc0;
        int          n;
        logic        found;
        logic [31:0] cap_pc;
        logic [31:0] cap_instr;

        rst              = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mem_req_ready_i  = 1'b1;
        instr_ready_i    = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("first_req_valid", mem_req_valid_o, 1);
        check("first_req_addr", mem_req_addr_o, 32'h0000_0100);

        // reset PC 0x100: A,B,C,D on consecutive cycles
        expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108); expect_pc(32'h10C);
        tick();
        drain("drain_reset_pc");
        idle(4);

        // redirect to a mid-packet target
        redirect(32'h0000_0208);
        expect_pc(32'h208); expect_pc(32'h20C); expect_pc(32'h210); expect_pc(32'h214);
        drain("drain_redirect_208");
        idle(4);

        // decode stalled: two requests only, head instruction stable
        redirect(32'h0000_0400);
        rc0 = req_count;
        idle(2);
        check("stall_valid", instr_valid_o, 1);
        check("stall_pc", instr_pc_o, 32'h0000_0400);
        check("stall_instr", instr_o, 32'hC0DE_0400);
        cap_pc    = instr_pc_o;
        cap_instr = instr_o;
        changes   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_pc_o !== cap_pc || instr_o !== cap_instr || instr_valid_o !== 1'b1)
                changes++;
        end
        check("stall_stable", changes, 0);
        check("stall_req_count", req_count - rc0, 2);
        expect_run(32'h400, 8);
        drain("drain_stall");
        idle(4);

        // redirect while a slow request is outstanding
        rsp_lat = 3;
        redirect(32'h0000_0500);
        wait_req("outstanding_req");
        redirect(32'h0000_0600);
        rsp_lat = 1;
        check("drop_blocks_req", mem_req_valid_o, 0);
        expect_run(32'h600, 4);
        drain("drain_after_drop");
        idle(4);

        // redirect together with a response and an instruction handshake
        redirect(32'h0000_0300);
        expect_run(32'h300, 8);
        instr_ready_i = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            tick();
            n++;
            if (mem_rsp_valid_i && instr_valid_o) found = 1'b1;
        end
        check("same_cycle_setup", found, 1);
        redirect(32'h0000_0340);
        check("same_cycle_flushed", instr_valid_o, 0);
        check("same_cycle_req_valid", mem_req_valid_o, 1);
        check("same_cycle_req_addr", mem_req_addr_o, 32'h0000_0340);
        expect_run(32'h340, 4);
        drain("drain_same_cycle");
        idle(4);

        // address wrap
        redirect(32'hFFFF_FFF0);
        expect_pc(32'hFFFF_FFF0); expect_pc(32'hFFFF_FFF4);
        expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000); expect_pc(32'h0000_0004);
        expect_pc(32'h0000_0008); expect_pc(32'h0000_000C);
        drain("drain_wrap");
        idle(4);

        // reset mid-stream with a response still pending
        rsp_lat = 3;
        redirect(32'h0000_0700);
        wait_req("pre_reset_req");
        rst = 1'b1;
        exp_q.delete();
        exp_fetch = 32'h0000_0100;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        rsp_lat = 1;
        expect_run(32'h100, 4);
        drain("drain_after_reset");
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
